mem_access_stage: RTL

- Memory stage of the rv32i pipeline. It consumes the execute stage's result (alu_out as address or result) and the store operand.
- Runs load/store transactions to data memory over a req/ack handshake. Aligns store data and generates byte enables. Extracts and sign/zero-extends load data.
- Presents one registered writeback record per accepted instruction.
- Stalls the upstream pipeline while a memory transaction is outstanding.

---
 rtl/mem_access_stage_if.sv | 22 ++
 rtl/mem_access_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the rv32i memory stage (master) and data memory.
interface mem_access_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       rdata;
    logic              ack;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// rv32i memory stage: runs loads/stores over a req/ack bus and registers one writeback record
// per instruction. Define MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating.
module mem_access_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic [31:0]               ex_alu_out,
    input  logic [31:0]               ex_store_data,
    input  logic [2:0]                ex_funct3,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic [4:0]                ex_rd,
    input  logic                      ex_reg_write,
    output logic                      stall,
    mem_access_stage_if.master        dmem,
    output logic                      wb_valid,
    output logic [4:0]                wb_rd,
    output logic                      wb_reg_write,
    output logic [31:0]               wb_data
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                      misaligned
`endif
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic              state;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_q;
    logic              reg_write_q;

    logic        is_mem;
    logic        misalign;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign stall      = (state == BUSY);
    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.be    = be_q;

    assign is_mem   = ex_mem_read | ex_mem_write;
    // funct3[1] set means word-sized; otherwise funct3[0] distinguishes half from byte.
    assign misalign = ex_funct3[1] ? (ex_alu_out[1:0] != 2'b00) : (ex_funct3[0] & ex_alu_out[0]);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ex_alu_out[1:0];
                wdata_d = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {ex_alu_out[1], 1'b0};
                wdata_d = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = dmem.rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
`ifdef MISALIGN_TRAP_EN
            misaligned   <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            if (state == IDLE) begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= ex_rd;
                        wb_reg_write <= ex_reg_write & (ex_rd != 5'd0);
                        wb_data      <= ex_alu_out;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (misalign) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= ex_rd;
                        wb_reg_write <= 1'b0;
                        wb_data      <= ex_alu_out;
                        misaligned   <= 1'b1;
                    end
`endif
                    else begin
                        // A write flag wins over a read flag.
                        state       <= BUSY;
                        req_q       <= 1'b1;
                        we_q        <= ex_mem_write;
                        addr_q      <= {ex_alu_out[ADDR_W-1:2], 2'b00};
                        wdata_q     <= wdata_d;
                        be_q        <= ex_mem_write ? be_d : 4'b0000;
                        funct3_q    <= ex_funct3;
                        off_q       <= ex_alu_out[1:0];
                        rd_q        <= ex_rd;
                        reg_write_q <= ex_reg_write & (ex_rd != 5'd0) & ~ex_mem_write;
                    end
                end
            end else if (dmem.ack) begin
                state        <= IDLE;
                req_q        <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= reg_write_q;
                if (!we_q) begin
                    wb_data <= load_data;
                end
            end
        end
    end

`ifndef MISALIGN_TRAP_EN
    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

endmodule
